// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the TX/RX queue controller states.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE
    } uart_q_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU-side push/status bus and transmitter launch handshake of the TX queue.
interface uart_tx_queue_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
);

    logic                   wr_en;
    logic [UART_DATA_W-1:0] wr_data;
    logic                   flush;
    logic                   enable;
    logic                   clr_ovf;
    logic                   full;
    logic                   empty;
    logic [AW:0]            count;
    logic                   overflow;
    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_busy;
    logic                   tx_done;

    modport slave (
        input  wr_en, wr_data, flush, enable, clr_ovf,
        input  tx_busy, tx_done,
        output full, empty, count, overflow,
        output tx_start, tx_data
    );

    modport master (
        output wr_en, wr_data, flush, enable, clr_ovf,
        output tx_busy, tx_done,
        input  full, empty, count, overflow,
        input  tx_start, tx_data
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with wrap-flag pointers and flush; shared by TX and RX.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [UART_DATA_W-1:0] wr_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [UART_DATA_W-1:0] rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [AW:0]            count_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic                   push;

    // Flush wins over a same-cycle push so the queue really ends up empty.
    assign push = wr_en_i && !full_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_tx_queue.sv
// TX byte queue feeding the UART transmitter one frame at a time.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           reset,
    uart_tx_queue_if.slave bus
);

    uart_q_state_e          state_q, state_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   ovf_q, ovf_d;
    logic                   pop;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [AW:0]            fifo_count;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (bus.wr_en),
        .wr_data_i (bus.wr_data),
        .pop_i     (pop),
        .flush_i   (bus.flush),
        .rd_data_o (rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable && !fifo_empty && !bus.flush) begin
                    pop       = 1'b1;
                    tx_data_d = rd_data;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A dropped write sets the flag even when clr_ovf arrives with it.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.wr_en && fifo_full && !bus.flush) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = ovf_q;
    assign bus.tx_start = (state_q == LAUNCH);
    assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a hand-driven transmitter handshake.
module tb_uart_tx_queue;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    uart_tx_queue_if #(.DEPTH(16)) bus();

    uart_tx_queue #(
        .DEPTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Wait (bounded) for a launch, check its byte, then play a short frame.
    task automatic serve(input string tag, input logic [7:0] exp);
        int k;
        k = 0;
        while (bus.tx_start !== 1'b1 && k < 12) begin
            tick();
            k++;
        end
        chk({tag, "_start"}, 32'(bus.tx_start), 32'd1);
        chk({tag, "_data"}, 32'(bus.tx_data), 32'(exp));
        tick();
        bus.tx_busy = 1'b1;
        tick();
        tick();
        tick();
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    initial begin
        int seen;
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush   = 1'b0;
        bus.enable  = 1'b1;
        bus.clr_ovf = 1'b0;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);

        // single byte, launch latency
        push(8'hA5);
        chk("sb_empty", 32'(bus.empty), 32'd0);
        chk("sb_count1", 32'(bus.count), 32'd1);
        chk("sb_nostart", 32'(bus.tx_start), 32'd0);
        tick();
        chk("sb_start", 32'(bus.tx_start), 32'd1);
        chk("sb_data", 32'(bus.tx_data), 32'hA5);
        chk("sb_count0", 32'(bus.count), 32'd0);
        tick();
        chk("sb_pulse1", 32'(bus.tx_start), 32'd0);
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.tx_start === 1'b1) seen++;
        end
        chk("sb_idle", 32'(seen), 32'd0);
        chk("sb_hold", 32'(bus.tx_data), 32'hA5);

        // fill and drain
        bus.enable = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fd_full", 32'(bus.full), 32'd1);
        chk("fd_count16", 32'(bus.count), 32'd16);
        chk("fd_ovf0", 32'(bus.overflow), 32'd0);
        push(8'h55);
        chk("fd_ovf1", 32'(bus.overflow), 32'd1);
        chk("fd_count_hold", 32'(bus.count), 32'd16);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("fd_ovf_clr", 32'(bus.overflow), 32'd0);
        bus.clr_ovf = 1'b1;
        push(8'h66);
        bus.clr_ovf = 1'b0;
        chk("fd_set_beats_clr", 32'(bus.overflow), 32'd1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        bus.enable = 1'b1;
        for (int i = 0; i < 16; i++) serve($sformatf("fd_f%0d", i), 8'(i));
        tick();
        chk("fd_empty", 32'(bus.empty), 32'd1);
        chk("fd_count0", 32'(bus.count), 32'd0);

        // simultaneous push and pop
        bus.enable = 1'b0;
        push(8'h11);
        chk("pp_count1", 32'(bus.count), 32'd1);
        bus.enable = 1'b1;
        push(8'h22);
        chk("pp_count_same", 32'(bus.count), 32'd1);
        chk("pp_start", 32'(bus.tx_start), 32'd1);
        serve("pp_a", 8'h11);
        serve("pp_b", 8'h22);
        tick();
        chk("pp_empty", 32'(bus.empty), 32'd1);

        // flush during WAIT_DONE
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        chk("fl_count5", 32'(bus.count), 32'd5);
        bus.enable = 1'b1;
        tick();
        chk("fl_start", 32'(bus.tx_start), 32'd1);
        chk("fl_data", 32'(bus.tx_data), 32'h30);
        chk("fl_count4", 32'(bus.count), 32'd4);
        tick();
        bus.tx_busy = 1'b1;
        tick();
        bus.flush   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h99;
        tick();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        chk("fl_count0", 32'(bus.count), 32'd0);
        chk("fl_empty", 32'(bus.empty), 32'd1);
        chk("fl_noovf", 32'(bus.overflow), 32'd0);
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.tx_start === 1'b1) seen++;
        end
        chk("fl_nolaunch", 32'(seen), 32'd0);
        chk("fl_hold", 32'(bus.tx_data), 32'h30);

        // spurious tx_done while idle and empty
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("sp_nostart", 32'(bus.tx_start), 32'd0);
        tick();
        chk("sp_nostart2", 32'(bus.tx_start), 32'd0);
        chk("sp_empty", 32'(bus.empty), 32'd1);
        push(8'h3C);
        tick();
        chk("sp_launch", 32'(bus.tx_start), 32'd1);
        chk("sp_data", 32'(bus.tx_data), 32'h3C);
        serve("sp", 8'h3C);

        // reset during WAIT_ACK with a full queue and overflow set
        bus.enable = 1'b0;
        for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
        chk("rs_ovf_pre", 32'(bus.overflow), 32'd1);
        bus.enable = 1'b1;
        tick();
        chk("rs_start_pre", 32'(bus.tx_start), 32'd1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("rs_start", 32'(bus.tx_start), 32'd0);
        chk("rs_data", 32'(bus.tx_data), 32'd0);
        chk("rs_empty", 32'(bus.empty), 32'd1);
        chk("rs_ovf", 32'(bus.overflow), 32'd0);
        chk("rs_count", 32'(bus.count), 32'd0);
        tick();
        #2;
        reset = 1'b1;
        tick();
        push(8'h77);
        chk("rs_nostart", 32'(bus.tx_start), 32'd0);
        tick();
        chk("rs_launch", 32'(bus.tx_start), 32'd1);
        chk("rs_ldata", 32'(bus.tx_data), 32'h77);
        serve("rs", 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
